// File: rtl/if_stage.sv
// Instruction fetch: at most one memory request in flight, responses queued for the decode stage.
// Optional IF_QUEUE_BYPASS_EN forwards a response to the outputs in the cycle it arrives.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        inst_ready_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o
);

    // state | meaning
    // IDLE  | nothing outstanding, may issue a request
    // WAIT  | one request outstanding, its response is kept
    // DROP  | one request outstanding, its response is discarded
    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_e;

    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = $clog2(QDEPTH + 1);

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_addr_q, req_addr_d;
    logic [31:0]   q_pc_q   [QDEPTH];
    logic [31:0]   q_pc_d   [QDEPTH];
    logic [31:0]   q_inst_q [QDEPTH];
    logic [31:0]   q_inst_d [QDEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic q_empty, q_full, req_fire, fwd_valid, fwd_taken, push, pop;

    assign q_empty    = (count_q == '0);
    assign q_full     = (count_q == CW'(QDEPTH));
    assign mem_req_o  = !rst && (state_q == IDLE) && !redirect_i && !q_full;
    assign mem_addr_o = fetch_pc_q;
    assign req_fire   = mem_req_o && mem_gnt_i;

`ifdef IF_QUEUE_BYPASS_EN
    assign fwd_valid = !rst && q_empty && (state_q == WAIT) && !redirect_i && mem_rvalid_i;
`else
    assign fwd_valid = 1'b0;
`endif
    assign fwd_taken = fwd_valid && inst_ready_i;

    always_comb begin
        inst_valid_o = 1'b0;
        inst_o       = '0;
        pc_o         = '0;
        if (!rst && !redirect_i) begin
            if (!q_empty) begin
                inst_valid_o = 1'b1;
                inst_o       = q_inst_q[rd_ptr_q];
                pc_o         = q_pc_q[rd_ptr_q];
            end else if (fwd_valid) begin
                inst_valid_o = 1'b1;
                inst_o       = mem_rdata_i;
                pc_o         = req_addr_q;
            end
        end
    end

    assign pop  = !q_empty && inst_valid_o && inst_ready_i;
    assign push = (state_q == WAIT) && mem_rvalid_i && !redirect_i && !fwd_taken;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        q_pc_d     = q_pc_q;
        q_inst_d   = q_inst_q;

        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i;
        end else if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            req_addr_d = fetch_pc_q;
        end

        // A grant is only expected for an asserted request; memory must not grant otherwise.
        unique case (state_q)
            IDLE: begin
                if (redirect_i && mem_gnt_i) state_d = DROP;
                else if (req_fire)           state_d = WAIT;
            end
            WAIT: begin
                if (mem_rvalid_i)    state_d = IDLE;
                else if (redirect_i) state_d = DROP;
            end
            DROP: begin
                if (mem_rvalid_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (redirect_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                q_pc_d[wr_ptr_q]   = req_addr_q;
                q_inst_d[wr_ptr_q] = mem_rdata_i;
                wr_ptr_d           = wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < int'(QDEPTH); i++) begin
                q_pc_q[i]   <= '0;
                q_inst_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            q_pc_q     <= q_pc_d;
            q_inst_q   <= q_inst_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a grant/response memory model feeds the fetch stage; expected words are
// queued when memory answers and compared as the stage hands them downstream.
`timescale 1ns/1ps
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          QDEPTH   = 2;
`ifdef IF_QUEUE_BYPASS_EN
    localparam int          FIRST_VALID = 2;
`else
    localparam int          FIRST_VALID = 3;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        inst_ready_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .inst_ready_i  (inst_ready_i),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .pc_o          (pc_o)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    // Memory: grants a request when enabled, answers one cycle later unless held.
    logic        gnt_en;
    logic        hold;
    logic        pend_q      = 1'b0;
    logic [31:0] pend_addr_q = 32'h0;

    assign mem_gnt_i    = gnt_en && mem_req_o;
    assign mem_rvalid_i = pend_q && !hold;
    assign mem_rdata_i  = mem_word(pend_addr_q);

    always @(posedge clk) begin
        if (rst) begin
            pend_q <= 1'b0;
        end else begin
            if (mem_rvalid_i) pend_q <= 1'b0;
            if (mem_gnt_i) begin
                pend_q      <= 1'b1;
                pend_addr_q <= mem_addr_o;
            end
        end
    end

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } item_t;

    item_t       sb[$];
    logic [31:0] pop_log[$];
    int          n_checks = 0;
    int          n_errs   = 0;
    logic [31:0] exp_fpc  = RESET_PC;
    logic [31:0] out_pc   = 32'h0;
    int unsigned epoch     = 0;
    int unsigned out_epoch = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] log_at(input int i);
        if (i < pop_log.size()) return pop_log[i];
        return 32'hxxxx_xxxx;
    endfunction

    // Evaluated at the falling edge: describes what the coming rising edge commits.
    task automatic mon_step();
        item_t it;
        if (rst) begin
            sb.delete();
            exp_fpc = RESET_PC;
            epoch++;
            return;
        end
        if (mem_rvalid_i && !redirect_i && out_epoch == epoch) begin
            it.pc   = out_pc;
            it.inst = mem_word(out_pc);
            sb.push_back(it);
        end
        if (inst_valid_o && inst_ready_i && !redirect_i) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(inst_valid_o), 32'd0);
            end else begin
                it = sb.pop_front();
                check("pop_pc", pc_o, it.pc);
                check("pop_inst", inst_o, it.inst);
            end
            pop_log.push_back(pc_o);
        end
        if (redirect_i) begin
            check("redir_valid", 32'(inst_valid_o), 32'd0);
            sb.delete();
            epoch++;
            exp_fpc = redirect_pc_i;
        end else if (mem_req_o && mem_gnt_i) begin
            check("fetch_addr", mem_addr_o, exp_fpc);
            out_pc    = exp_fpc;
            out_epoch = epoch;
            exp_fpc   = exp_fpc + 32'd4;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int first_valid;
        bit found;

        rst           = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        inst_ready_i  = 1'b1;
        gnt_en        = 1'b1;
        hold          = 1'b0;

        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
        join_none

        // Reset state, then streaming with 1-cycle memory.
        repeat (2) tick();
        check("rst_req", 32'(mem_req_o), 32'd0);
        check("rst_valid", 32'(inst_valid_o), 32'd0);
        check("rst_inst", inst_o, 32'd0);
        check("rst_pc", pc_o, 32'd0);
        check("rst_addr", mem_addr_o, RESET_PC);
        rst = 1'b0;
        first_valid = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (inst_valid_o && first_valid == 0) first_valid = c;
        end
        check("first_valid_cycle", 32'(first_valid), 32'(FIRST_VALID));
        for (int i = 0; i < 4; i++) check("stream_pc", log_at(i), 32'(4 * i));

        // Downstream stall fills the queue, then drains in order.
        tick();
        inst_ready_i = 1'b0;
        repeat (10) tick();
        check("stall_req", 32'(mem_req_o), 32'd0);
        check("stall_valid", 32'(inst_valid_o), 32'd1);
        check("stall_fill", 32'(sb.size()), 32'(QDEPTH));
        inst_ready_i = 1'b1;
        repeat (12) tick();

        // Grant withheld: request and address hold steady.
        gnt_en = 1'b0;
        repeat (3) tick();
        for (int c = 0; c < 5; c++) begin
            check("nognt_req", 32'(mem_req_o), 32'd1);
            check("nognt_addr", mem_addr_o, exp_fpc);
            tick();
        end
        gnt_en = 1'b1;
        repeat (4) tick();

        // Redirect while a request is outstanding: stale response dropped.
        hold = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            tick();
            if (pend_q) found = 1'b1;
        end
        check("reach_wait", 32'(found), 32'd1);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h100;
        pop_log.delete();
        tick();
        redirect_i = 1'b0;
        hold       = 1'b0;
        @(negedge clk);
        check("drop_req", 32'(mem_req_o), 32'd0);
        repeat (8) tick();
        check("redir_pc", log_at(0), 32'h100);
        check("redir_pc_next", log_at(1), 32'h104);

        // Redirect coincident with a response while the queue holds a word.
        inst_ready_i = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            tick();
            if (mem_rvalid_i && sb.size() >= 1) found = 1'b1;
        end
        check("reach_rvalid_nonempty", 32'(found), 32'd1);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h200;
        tick();
        redirect_i = 1'b0;
        @(negedge clk);
        check("flush_valid", 32'(inst_valid_o), 32'd0);
        check("flush_req", 32'(mem_req_o), 32'd1);
        check("flush_addr", mem_addr_o, 32'h200);
        tick();
        inst_ready_i = 1'b1;
        repeat (6) tick();

        // Reset while waiting on memory.
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            tick();
            if (pend_q) found = 1'b1;
        end
        check("reach_wait_rst", 32'(found), 32'd1);
        rst = 1'b1;
        tick();
        check("rst2_req", 32'(mem_req_o), 32'd0);
        check("rst2_valid", 32'(inst_valid_o), 32'd0);
        check("rst2_inst", inst_o, 32'd0);
        check("rst2_pc", pc_o, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst2_first_req", 32'(mem_req_o), 32'd1);
        check("rst2_first_addr", mem_addr_o, RESET_PC);
        repeat (6) tick();

        // Fetch PC wraps from the top of the address space.
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        pop_log.delete();
        tick();
        redirect_i = 1'b0;
        repeat (10) tick();
        check("wrap_top", log_at(0), 32'hFFFF_FFFC);
        check("wrap_zero", log_at(1), 32'h0000_0000);

        // Stop memory and let everything drain.
        gnt_en = 1'b0;
        repeat (6) tick();
        check("end_sb_left", 32'(sb.size()), 32'd0);
        check("end_valid", 32'(inst_valid_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter QDEPTH, default 2, the instruction queue depth; legal values are 2 or 4.
REQ-003 SHALL have port clk, input, 1, the clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, the reset: synchronous, active-high.
REQ-005 SHALL have port redirect_i, input, 1, the branch/jump redirect strobe.
REQ-006 SHALL have port redirect_pc_i, input, 32, the redirect target.
REQ-007 SHALL have port inst_ready_i, input, 1, asserted when the downstream IF/ID register accepts (not stalled).
REQ-008 SHALL have port mem_req_o, output, 1, the fetch request.
REQ-009 SHALL have port mem_addr_o, output, 32, the fetch address.
REQ-010 SHALL have port mem_gnt_i, input, 1, signalling that memory accepted the request this cycle.
REQ-011 SHALL have port mem_rvalid_i, input, 1, signalling that response data is valid this cycle.
REQ-012 SHALL have port mem_rdata_i, input, 32, the response instruction word.
REQ-013 SHALL have port inst_valid_o, output, 1, asserted when an instruction is offered downstream.
REQ-014 SHALL have port inst_o, output, 32, the offered instruction.
REQ-015 SHALL have port pc_o, output, 32, the address of inst_o.

Function
REQ-016 SHALL implement an FSM with states IDLE, WAIT (one request outstanding) and DROP (outstanding response to be discarded).
REQ-017 SHALL assert mem_req_o only in IDLE, with redirect_i low and (queue count) < QDEPTH; mem_addr_o = fetch PC.
REQ-018 SHALL, on mem_req_o && mem_gnt_i: record the request address, advance fetch PC by +4 (mod 2^32; 32'hFFFF_FFFC wraps to 0), and go IDLE->WAIT.
REQ-019 SHALL hold mem_req_o and mem_addr_o stable while mem_gnt_i is low.
REQ-020 SHALL, in WAIT on mem_rvalid_i, push {recorded address, mem_rdata_i} into the queue and return to IDLE; the next request may issue the following cycle.
REQ-021 SHALL never have more than one request outstanding, so the queue cannot overflow.
REQ-022 SHALL present the queue head on inst_valid_o/inst_o/pc_o and pop it when inst_valid_o && inst_ready_i.
REQ-023 SHALL allow a push and a pop in the same cycle, leaving the count unchanged.
REQ-024 SHALL, on redirect_i: flush the queue, deassert inst_valid_o in that cycle, and load fetch PC with redirect_pc_i.
REQ-025 SHALL, on redirect_i in WAIT without mem_rvalid_i, go to DROP.
REQ-026 SHALL, on redirect_i in IDLE coincident with a grant, go to DROP.
REQ-027 SHALL, on redirect_i coincident with mem_rvalid_i, discard the response and go to IDLE.
REQ-028 SHALL, in DROP, discard the next mem_rvalid_i response without pushing it, then go to IDLE.
REQ-029 SHALL, on a further redirect_i in DROP, stay in DROP and update fetch PC.
REQ-030 SHALL ignore mem_rvalid_i in IDLE.

Reset
REQ-031 SHALL, while rst is high at a clock edge, set: state=IDLE, fetch PC=RESET_PC, queue empty, inst_valid_o=0, inst_o=0, pc_o=0, mem_req_o=0.
REQ-032 SHALL, on rst asserted mid-request, abandon the outstanding request; the memory is reset by the same rst.
REQ-033 SHALL allow the first request in the cycle after rst deasserts.

Configuration
REQ-034 SHALL, with IF_QUEUE_BYPASS_EN defined, forward a response combinationally (inst_valid_o=1, inst_o=mem_rdata_i, pc_o=recorded address) when the queue is empty, the state is WAIT and redirect_i is low: 0-cycle latency from mem_rvalid_i.
REQ-035 SHALL, under IF_QUEUE_BYPASS_EN, skip the push when the forwarded response is accepted by inst_ready_i, and push it otherwise.
REQ-036 SHALL, with IF_QUEUE_BYPASS_EN undefined, route all responses through the queue: inst_valid_o rises 1 cycle after mem_rvalid_i.

Verification
REQ-037 SHALL cover reset then 1-cycle grant/response memory, inst_ready_i=1 -> pc_o sequence 0,4,8,C with matching inst_o; first inst_valid_o at cycle 3 (bypass undefined) or 2 (defined).
REQ-038 SHALL cover inst_ready_i=0 for 10 cycles -> count reaches QDEPTH, mem_req_o stays 0, no word lost; on release the words drain in order.
REQ-039 SHALL cover redirect_i with redirect_pc_i=32'h100 while in WAIT -> stale response dropped; next pc_o=32'h100.
REQ-040 SHALL cover redirect_i coincident with mem_rvalid_i and a non-empty queue -> queue empty, inst_valid_o=0 next cycle, next mem_addr_o=redirect target.
REQ-041 SHALL cover mem_gnt_i held low for 5 cycles -> mem_addr_o stable throughout and fetch PC advanced only once.
REQ-042 SHALL cover rst pulsed in WAIT -> all outputs 0, and mem_addr_o=RESET_PC next cycle.
